sr_ff_bank: RTL and testbench

Parametrised bank of WIDTH clocked SR flip-flops, one per channel, with a selectable policy for the S=R=1 condition. Each channel's next-state update is registered on the clock. Conflict (S=R=1) cycles are detected and counted for debug. The bank is the clocked, multi-channel successor to the single-bit SR NAND latch and serves as a status/flag register bank in the practice designs.

---
 rtl/sr_ff_pkg.sv | 31 +++
 rtl/sr_ff_cell.sv | 41 ++++
 rtl/sr_ff_bank.sv | 107 ++++++++++
 tb/tb_sr_ff_bank.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sr_ff_pkg.sv
// Shared definitions for the SR flip-flop bank: the S=R=1 policy codes and
// the per-channel next-state function used by every cell.
package sr_ff_pkg;

  localparam int unsigned SR_MODE_HOLD = 0;
  localparam int unsigned SR_MODE_SET  = 1;
  localparam int unsigned SR_MODE_RST  = 2;
  localparam int unsigned SR_MODE_TGL  = 3;

  // Next value of one channel given its set/reset inputs and current state.
  function automatic logic next_q(input int unsigned mode, input logic s,
                                  input logic r, input logic q);
    logic nq;
    nq = q;
    case ({s, r})
      2'b10: nq = 1'b1;
      2'b01: nq = 1'b0;
      2'b00: nq = q;
      default: begin
        case (mode)
          SR_MODE_SET: nq = 1'b1;
          SR_MODE_RST: nq = 1'b0;
          SR_MODE_TGL: nq = ~q;
          default:     nq = q;
        endcase
      end
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// Single clocked SR channel. q and q_n come from two registers that are
// always loaded together, so q_n is never an independent state.
module sr_ff_cell
  import sr_ff_pkg::*;
#(
  parameter int unsigned MODE = SR_MODE_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  input  logic rst_val,
  output logic q,
  output logic q_n
);

  logic q_q, q_d;
  logic q_n_q;

  // Next state: apply the SR rule only when the bank is enabled.
  always_comb begin
    q_d = q_q;
    if (en) q_d = next_q(MODE, s, r, q_q);
  end

  // State register pair with asynchronous reset to the channel's reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= rst_val;
      q_n_q <= ~rst_val;
    end else begin
      q_q   <= q_d;
      q_n_q <= ~q_d;
    end
  end

  assign q   = q_q;
  assign q_n = q_n_q;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH clocked SR flip-flops with a common S=R=1 policy (MODE),
// a registered conflict flag and a saturating conflict counter.
// Optional macro SR_FF_BANK_SYNC_EN: passes s, r and en through a 2-flop
// synchroniser before the update logic (s/r -> q latency becomes 3 cycles).
module sr_ff_bank
  import sr_ff_pkg::*;
#(
  parameter int unsigned       WIDTH   = 8,
  parameter int unsigned       MODE    = SR_MODE_HOLD,
  parameter logic [WIDTH-1:0]  RST_VAL = '0,
  parameter int unsigned       CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  if (MODE > SR_MODE_TGL) begin : g_bad_mode
    $error("sr_ff_bank: MODE must be 0..3");
  end

  logic [WIDTH-1:0] s_use, r_use;
  logic             en_use;

`ifdef SR_FF_BANK_SYNC_EN
  logic [WIDTH-1:0] s_meta_q, s_sync_q, r_meta_q, r_sync_q;
  logic             en_meta_q, en_sync_q;

  // Two-stage synchroniser on all update controls; cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta_q  <= '0;
      s_sync_q  <= '0;
      r_meta_q  <= '0;
      r_sync_q  <= '0;
      en_meta_q <= 1'b0;
      en_sync_q <= 1'b0;
    end else begin
      s_meta_q  <= s;
      s_sync_q  <= s_meta_q;
      r_meta_q  <= r;
      r_sync_q  <= r_meta_q;
      en_meta_q <= en;
      en_sync_q <= en_meta_q;
    end
  end

  assign s_use  = s_sync_q;
  assign r_use  = r_sync_q;
  assign en_use = en_sync_q;
`else
  assign s_use  = s;
  assign r_use  = r;
  assign en_use = en;
`endif

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    sr_ff_cell #(
      .MODE(MODE)
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .en     (en_use),
      .s      (s_use[gi]),
      .r      (r_use[gi]),
      .rst_val(RST_VAL[gi]),
      .q      (q[gi]),
      .q_n    (q_n[gi])
    );
  end

  logic             conflict_q, conflict_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Conflict detection and saturating count; clear wins over increment.
  always_comb begin
    conflict_d = en_use & (|(s_use & r_use));
    cnt_d      = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (conflict_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debug registers for the conflict flag and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Scoreboard bench for sr_ff_bank: four instances (MODE 0..3) share one
// stimulus stream; expected results are queued per cycle and checked by an
// independent monitor one time unit after each rising edge.
module tb_sr_ff_bank;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 3;
  localparam logic [3:0]  RV = 4'b0101;

  logic       clk = 1'b0;
  logic       rst, en, clr_cnt;
  logic [3:0] s, r;

  logic [3:0] q_w  [4];
  logic [3:0] qn_w [4];
  logic       conf_w [4];
  logic [2:0] cnt_w  [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    sr_ff_bank #(
      .WIDTH  (W),
      .MODE   (gi),
      .RST_VAL(RV),
      .CNT_W  (CW)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .s           (s),
      .r           (r),
      .clr_cnt     (clr_cnt),
      .q           (q_w[gi]),
      .q_n         (qn_w[gi]),
      .conflict    (conf_w[gi]),
      .conflict_cnt(cnt_w[gi])
    );
  end

  // Clock held low for the first 20 ns so reset is observed with no edge.
  initial begin
    #20;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [15:0] q;
    logic        conf;
    logic [2:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state
  logic [3:0] mq [4];
  logic       mconf;
  logic [2:0] mcnt;
  logic [3:0] d1_s, d1_r, d2_s, d2_r;
  logic       d1_en, d2_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t cur_exp();
    exp_t e;
    for (int m = 0; m < 4; m++) e.q[m*4 +: 4] = mq[m];
    e.conf = mconf;
    e.cnt  = mcnt;
    return e;
  endfunction

  task automatic check_all(input exp_t e);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("q_m%0d", m),    {28'd0, q_w[m]},   {28'd0, e.q[m*4 +: 4]});
      chk($sformatf("q_n_m%0d", m),  {28'd0, qn_w[m]},  {28'd0, ~e.q[m*4 +: 4]});
      chk($sformatf("conf_m%0d", m), {31'd0, conf_w[m]}, {31'd0, e.conf});
      chk($sformatf("cnt_m%0d", m),  {29'd0, cnt_w[m]},  {29'd0, e.cnt});
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 4; m++) mq[m] = RV;
    mconf = 1'b0;
    mcnt  = 3'd0;
    d1_s = '0; d1_r = '0; d2_s = '0; d2_r = '0;
    d1_en = 1'b0; d2_en = 1'b0;
  endtask

  // One clock of the reference: channel rules written from the truth table.
  task automatic model_step(input logic [3:0] si, input logic [3:0] ri,
                            input logic ei, input logic ci);
    logic [3:0] us, ur;
    logic       ue;
`ifdef SR_FF_BANK_SYNC_EN
    us = d2_s; ur = d2_r; ue = d2_en;
    d2_s = d1_s; d2_r = d1_r; d2_en = d1_en;
    d1_s = si;   d1_r = ri;   d1_en = ei;
`else
    us = si; ur = ri; ue = ei;
`endif
    for (int m = 0; m < 4; m++) begin
      if (ue) begin
        for (int b = 0; b < 4; b++) begin
          if (us[b] && !ur[b])      mq[m][b] = 1'b1;
          else if (!us[b] && ur[b]) mq[m][b] = 1'b0;
          else if (us[b] && ur[b]) begin
            if (m == 1)      mq[m][b] = 1'b1;
            else if (m == 2) mq[m][b] = 1'b0;
            else if (m == 3) mq[m][b] = ~mq[m][b];
          end
        end
      end
    end
    mconf = ue && ((us & ur) != 4'd0);
    if (ci)                      mcnt = 3'd0;
    else if (mconf && mcnt != 7) mcnt = mcnt + 3'd1;
  endtask

  // Drive one cycle of stimulus and queue what the outputs must show after it.
  task automatic apply(input logic [3:0] si, input logic [3:0] ri,
                       input logic ei, input logic ci);
    @(negedge clk);
    s = si; r = ri; en = ei; clr_cnt = ci;
    model_step(si, ri, ei, ci);
    sb.push_back(cur_exp());
  endtask

  // Monitor: every rising edge with a queued expectation is checked.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) check_all(sb.pop_front());
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; s = '0; r = '0; clr_cnt = 1'b0;
    model_reset();
    #10;
    check_all(cur_exp());
    #2 rst = 1'b0;

    // Set, reset, hold
    apply(4'b0011, 4'b0000, 1'b1, 1'b0);
    apply(4'b0000, 4'b0001, 1'b1, 1'b0);
    apply(4'b0000, 4'b0000, 1'b1, 1'b0);
    // S=R=1 on all channels: hold / set / reset / toggle
    apply(4'b1111, 4'b1111, 1'b1, 1'b0);
    apply(4'b0000, 4'b0000, 1'b1, 1'b0);
    // Counter saturation, then clear together with a conflict
    repeat (9) apply(4'b0001, 4'b0001, 1'b1, 1'b0);
    apply(4'b0001, 4'b0001, 1'b1, 1'b1);
    apply(4'b0010, 4'b0010, 1'b1, 1'b0);
    // Disabled: no update, no conflict, counter frozen
    apply(4'b1111, 4'b0000, 1'b0, 1'b0);
    apply(4'b1111, 4'b1111, 1'b0, 1'b0);
    apply(4'b0000, 4'b0000, 1'b1, 1'b1);
    apply(4'b1010, 4'b0101, 1'b1, 1'b0);
    apply(4'b0000, 4'b0000, 1'b1, 1'b0);
    apply(4'b0000, 4'b0000, 1'b1, 1'b0);

    // Reset asserted between edges while an update is pending
    @(negedge clk);
    s = 4'b1111; r = 4'b0000; en = 1'b1; clr_cnt = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1 check_all(cur_exp());
    s = '0; r = '0;
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle set pulse on channel 0, then idle to observe latency
    apply(4'b0001, 4'b0000, 1'b1, 1'b0);
    repeat (4) apply(4'b0000, 4'b0000, 1'b1, 1'b0);
    apply(4'b1000, 4'b1000, 1'b1, 1'b0);
    repeat (3) apply(4'b0000, 4'b0000, 1'b1, 1'b0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    chk("drain", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
